// File: rtl/config_axil_read_bridge_if.sv
// AXI-Lite width constants and the config register read request/response interface.
package config_axil_pkg;
  localparam int AXIL_ADDR_BITS = 32;
  localparam int AXIL_DATA_BITS = 32;
endpackage

interface read_config_i;
  import config_axil_pkg::*;
  logic                      read_valid;
  logic                      read_ready;
  logic [AXIL_ADDR_BITS-1:0] read_addr;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [AXIL_DATA_BITS-1:0] resp_data;
  logic                      resp_error;

  modport m (
    output read_valid, read_addr, resp_ready,
    input  read_ready, resp_valid, resp_data, resp_error
  );
  modport s (
    input  read_valid, read_addr, resp_ready,
    output read_ready, resp_valid, resp_data, resp_error
  );
endinterface

// File: rtl/config_axil_read_bridge.sv
// AXI-Lite read channel to config read request/response, one transaction in flight, AR-to-R >= 3 cycles.
// rready stalls only the R beat; an unanswered config read times out to DECERR and its late response is dropped.
module config_axil_read_bridge
  import config_axil_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXIL_ADDR_BITS-1:0] s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [AXIL_DATA_BITS-1:0] s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  read_config_i.m                   conf
);
  localparam int               CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;
  localparam logic [1:0]       RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                    r_state, w_state_nxt;
  logic                      r_stale, w_stale_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic [AXIL_DATA_BITS-1:0] r_rdata, w_rdata_nxt;
  logic [1:0]                r_rresp, w_rresp_nxt;
  logic [AXIL_ADDR_BITS-1:0] r_read_addr, w_read_addr_nxt;
  logic                      r_arready, r_rvalid, r_read_valid, r_resp_ready;
  logic                      w_ar_hs, w_req_hs, w_resp_hs, w_r_hs, w_timeout;

  assign w_ar_hs   = r_arready & s_axil_arvalid;
  assign w_req_hs  = r_read_valid & conf.read_ready;
  assign w_resp_hs = r_resp_ready & conf.resp_valid;
  assign w_r_hs    = r_rvalid & s_axil_rready;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_MAX) &&
                     ((r_state == REQ) || (r_state == WAIT));

  always_comb begin
    w_state_nxt     = r_state;
    w_stale_nxt     = r_stale;
    w_cnt_nxt       = r_cnt;
    w_rdata_nxt     = r_rdata;
    w_rresp_nxt     = r_rresp;
    w_read_addr_nxt = r_read_addr;

    // Counter stops at the limit so a request that squeaks in on the last
    // REQ cycle still gets a bounded wait for its response.
    if (((r_state == REQ) || (r_state == WAIT)) && (r_cnt != CNT_MAX))
      w_cnt_nxt = r_cnt + CNT_W'(1);

    if (r_stale && w_resp_hs)
      w_stale_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_ar_hs) begin
          w_read_addr_nxt = s_axil_araddr;
          w_cnt_nxt       = '0;
          w_state_nxt     = REQ;
        end
      end
      REQ: begin
        if (w_req_hs) begin
          w_state_nxt = WAIT;
        end else if (w_timeout) begin
          w_rdata_nxt = '0;
          w_rresp_nxt = RESP_DECERR;
          w_state_nxt = RESP;
        end
      end
      WAIT: begin
        if (w_resp_hs) begin
          w_rdata_nxt = conf.resp_data;
          w_rresp_nxt = conf.resp_error ? RESP_SLVERR : RESP_OKAY;
          w_state_nxt = RESP;
        end else if (w_timeout) begin
          w_rdata_nxt = '0;
          w_rresp_nxt = RESP_DECERR;
          w_stale_nxt = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (w_r_hs)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_stale      <= 1'b0;
      r_cnt        <= '0;
      r_rdata      <= '0;
      r_rresp      <= '0;
      r_read_addr  <= '0;
      r_arready    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_read_valid <= 1'b0;
      r_resp_ready <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_stale      <= w_stale_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rdata      <= w_rdata_nxt;
      r_rresp      <= w_rresp_nxt;
      r_read_addr  <= w_read_addr_nxt;
      r_arready    <= (w_state_nxt == IDLE) && !w_stale_nxt;
      r_rvalid     <= (w_state_nxt == RESP);
      r_read_valid <= (w_state_nxt == REQ);
      r_resp_ready <= (w_state_nxt == WAIT) || w_stale_nxt;
    end
  end

  assign s_axil_arready  = r_arready;
  assign s_axil_rvalid   = r_rvalid;
  assign s_axil_rdata    = r_rdata;
  assign s_axil_rresp    = r_rresp;
  assign conf.read_valid = r_read_valid;
  assign conf.read_addr  = r_read_addr;
  assign conf.resp_ready = r_resp_ready;
endmodule

// File: doc/config_axil_read_bridge.md
# config_axil_read_bridge

Bridges the AXI4-Lite read channel of the host control port onto the `read_config_i` request/response interface that feeds the config read registers. It accepts one AR transaction at a time and forwards its address as a config read request. It returns the register's data and error status as an AXI-Lite R beat. A timeout turns an unanswered read into DECERR so the host bus never hangs.

## Interface
- `TIMEOUT_CYCLES`, default 1024: cycles allowed from AR acceptance to config response; 0 disables the timeout.
- Data width is the package constant `AXIL_DATA_BITS`; address width is `AXIL_ADDR_BITS`.

- `clk` in 1: single clock; everything is synchronous to the rising edge.
- `rst` in 1: **one clock; reset is asynchronous and active-high.** All state and outputs clear immediately when `rst` asserts.
- `s_axil_araddr` in `AXIL_ADDR_BITS`: read address.
- `s_axil_arvalid` in 1 / `s_axil_arready` out 1: AR handshake.
- `s_axil_rdata` out `AXIL_DATA_BITS`: read data.
- `s_axil_rresp` out 2: read response code.
- `s_axil_rvalid` out 1 / `s_axil_rready` in 1: R handshake.
- `conf` modport `read_config_i.m`, master side:
  - drives `read_valid`, `read_addr`, `resp_ready`;
  - samples `read_ready`, `resp_valid`, `resp_data`, `resp_error`.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - `s_axil_arready`=1 unless `stale`=1.
  - On an AR handshake: latch `araddr` into `read_addr`, clear the timeout counter, go to REQ.
- **REQ**
  - `read_valid`=1 and `read_addr` is held stable.
  - On `read_valid && read_ready`, go to WAIT.
- **WAIT**
  - `resp_ready`=1.
  - On `resp_valid && resp_ready`:
    - latch `resp_data` into `rdata`;
    - `rresp` = 2'b10 (SLVERR) if `resp_error`, else 2'b00 (OKAY);
    - go to RESP.
- **RESP**
  - `s_axil_rvalid`=1; `rdata`/`rresp` are held stable.
  - On `rvalid && rready`, go to IDLE.
- **Timeout**
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`. It increments every cycle in REQ or WAIT and saturates.
  - When the counter equals `TIMEOUT_CYCLES` (nonzero), go to RESP with `rdata`=0 and `rresp`=2'b11 (DECERR).
  - Timeout in REQ: drop `read_valid` (request withdrawn).
  - Timeout in WAIT: set the `stale` flag.
  - While `stale`=1:
    - `resp_ready`=1 in every state;
    - `s_axil_arready`=0;
    - the next `resp_valid` is consumed and discarded, which clears `stale`.
- **Simultaneous events**
  - If the timeout hits in the same cycle as a completing handshake (`read_ready` in REQ, `resp_valid` in WAIT), the handshake wins and the timeout is ignored.
- **Data handling**
  - `resp_data` and `rdata` are the same width; there is no truncation or extension.
  - `araddr` passes to `read_addr` unmodified.
- **Reset values**
  - State IDLE, `stale`=0, counter 0.
  - `s_axil_arready`=0, `s_axil_rvalid`=0, `s_axil_rresp`=0, `s_axil_rdata`=0.
  - `read_valid`=0, `read_addr`=0, `resp_ready`=0.
- **Reset mid-transaction**
  - The transaction is abandoned; nothing is replayed.
  - A late config response after reset release is not expected; the config registers are reset by the same domain.

## Timing
- All outputs are registered.
- `s_axil_arready` first rises the cycle after `rst` deasserts.
- Cycle-level sequence for a register that accepts immediately:
  - cycle n: AR handshake;
  - n+1: `read_valid`=1 (`read_ready`=1 accepts);
  - n+2: `resp_ready`=1; the register shows `resp_valid`, handshake;
  - n+3: `s_axil_rvalid`=1.
- Minimum AR-to-R latency: 3 cycles.
- `s_axil_arready` is 0 from cycle n+1 until the cycle after the R handshake, so back-to-back reads are spaced ≥4 cycles apart.
- Host backpressure on `rready` stalls only RESP; stalled cycles are not counted by the timeout.
- Timeout fires exactly `TIMEOUT_CYCLES` cycles after entering REQ; `rvalid` follows on the next cycle.

## Test plan
- **Good read:** AR `araddr`=0x10; register returns 0xDEADBEEF with `resp_error`=0 -> `rdata`=0xDEADBEEF, `rresp`=00, `rvalid` at n+3.
- **Bad address:** register returns `resp_error`=1 -> `rresp`=2'b10, `rdata` equals the register's `resp_data`.
- **Host stall:** `rready` held 0 for 10 cycles -> `rvalid`/`rdata` stable; `arready`=0 throughout; no second `read_valid`.
- **No responder, `TIMEOUT_CYCLES`=8:** `read_ready` stuck at 1, `resp_valid` never asserts -> `rresp`=2'b11, `rdata`=0. A later stale `resp_valid` is absorbed; after that, AR to 0x20 completes OKAY with the correct data.
- **Race:** `resp_valid` arrives on the exact timeout cycle -> OKAY with real data, `stale` stays 0.
- **Async reset:** `rst` asserted while in WAIT -> all outputs 0 immediately; `arready`=1 one cycle after release.
